fetch_r32i: RTL and testbench
=============================

Name: fetch_r32i

Overview:
Instruction fetch stage directly downstream of the RV32I program counter. It samples the program address and issues one outstanding request at a time on a req/gnt/rvalid instruction-memory bus. Returned words go into a 2-entry buffer, which presents them to decode with a valid/ready handshake. Flush discards buffered and in-flight instructions on a taken branch or jump.

Parameters:
dataW, 32, instruction/data width
addrW, 32, address width
BufDepth, 2, instruction buffer entries (power of two, ≥2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ProgAddr  input  addrW  current program address from the PC
FetchEn  input  1  permits new requests when high
Flush  input  1  discard buffer and in-flight response
imem_req  output  1  memory request valid
imem_addr  output  addrW  request address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  dataW  response instruction word
Instr  output  dataW  buffer head instruction
InstrAddr  output  addrW  address of Instr
InstrValid  output  1  buffer non-empty
InstrReady  input  1  decode accepts Instr
PcAdvance  output  1  pulse: address consumed (imem_req && imem_gnt)
FetchErr  output  1  misaligned fetch flag (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE, buffer empty; imem_req=0, imem_addr=0, InstrValid=0, Instr=0x00000013 (NOP), InstrAddr=0, PcAdvance=0, FetchErr=0.
- FSM states: IDLE, REQ, WAIT, DROP.
- Space condition: count + (state==WAIT) < BufDepth.
- IDLE → REQ when FetchEn && space. Sample ProgAddr with bits[1:0] forced to 00 into imem_addr. imem_req is registered and goes high the next cycle.
- REQ: imem_req=1. imem_addr is held stable until imem_gnt. On gnt: → WAIT, PcAdvance=1 that cycle.
- WAIT: on imem_rvalid, write {imem_rdata, imem_addr} to buffer tail. Then go to REQ with a newly sampled ProgAddr if FetchEn && space-after-write; otherwise go to IDLE.
- Minimum latency: gnt at cycle t, rvalid at t+1, InstrValid high at t+2.
- Pop when InstrValid && InstrReady. Push and pop in the same cycle leave count unchanged.
- Instr and InstrAddr are driven from the buffer head. When empty, Instr shows NOP.
- Flush (synchronous, highest priority): buffer emptied that cycle, any same-cycle pop ignored.
  - IDLE: stays IDLE.
  - REQ: imem_req stays high until gnt (bus rule), then → DROP.
  - WAIT: → DROP.
  - DROP: discards the next rvalid without writing the buffer, then → IDLE.
  - Flush in DROP: no additional effect.
- rvalid outside WAIT/DROP is a protocol error and is ignored.
- Buffer pointers wrap modulo BufDepth. A push when full is impossible by construction of the space condition; assert on it in simulation.
- FetchEn low never cancels a request in progress. It only blocks new requests.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: if sampled ProgAddr[1:0]!=0, no request is issued. FetchErr is set and held until Flush or reset, and the FSM stays IDLE.
- Undefined: low bits are silently forced to 00 and FetchErr is tied 0.

Decomposition:
- Package fetch_pkg_r32i:
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP}
  - NOP_INSTR = 32'h00000013
  - entry struct {addr, instr}
- Sub-module fetch_fifo_r32i: parameterised synchronous FIFO with push, pop, clear, count, head outputs and async reset. The FSM stays in the top.

Test Plan:
- Reset mid-WAIT → same cycle: imem_req=0, InstrValid=0, Instr=0x00000013. After release with FetchEn=1, the first request has imem_addr=ProgAddr.
- ProgAddr=0x100, gnt immediately, rvalid next cycle with 0x00500093, InstrReady=1 → InstrValid two cycles after gnt, Instr=0x00500093, InstrAddr=0x100, PcAdvance one pulse.
- InstrReady=0, memory always responds → exactly 2 entries (0x0, 0x4). No further imem_req until one pop, then the next request goes to the current ProgAddr.
- Flush asserted during WAIT for addr 0x8 → buffer empties. Response 0xDEADBEEF is dropped, InstrValid stays 0, and the next request follows ProgAddr.
- Flush and InstrReady in the same cycle with 2 entries → count 0 and no double pop. Flush while in REQ with gnt delayed 3 cycles → imem_addr held stable, response dropped.
- With FETCH_MISALIGN_CHECK_EN defined and ProgAddr=0x102 → imem_req stays 0 and FetchErr=1 until Flush. Without the macro → imem_addr=0x100 and FetchErr=0.

Source files
------------

// File: rtl/fetch_r32i_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg_r32i;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

endpackage

// File: rtl/fetch_r32i_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage and memory.
interface fetch_r32i_if #(
    parameter int dataW = 32,
    parameter int addrW = 32
) ();
    logic             imem_req;
    logic [addrW-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [dataW-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_r32i_fifo.sv
// Synchronous FIFO with clear, occupancy count and head output (Depth power of two).
module fetch_fifo_r32i #(
    parameter int Width = 64,
    parameter int Depth = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [Width-1:0]       wdata,
    output logic [Width-1:0]       head,
    output logic [$clog2(Depth):0] count,
    output logic                   empty
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic             full, push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/fetch_r32i.sv
// RV32I fetch stage: one outstanding imem request, 2-entry buffer to decode.
// Build option FETCH_MISALIGN_CHECK_EN: refuse misaligned PCs and raise FetchErr.
//
// state | meaning
// IDLE  | no request outstanding, waiting for FetchEn and buffer space
// REQ   | imem_req high, address held until gnt
// WAIT  | granted, response will be written to the buffer
// DROP  | granted before a flush, next response is discarded
module fetch_r32i
    import fetch_pkg_r32i::*;
#(
    parameter int dataW    = 32,
    parameter int addrW    = 32,
    parameter int BufDepth = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [addrW-1:0] ProgAddr,
    input  logic             FetchEn,
    input  logic             Flush,
    fetch_r32i_if.master     imem,
    output logic [dataW-1:0] Instr,
    output logic [addrW-1:0] InstrAddr,
    output logic             InstrValid,
    input  logic             InstrReady,
    output logic             PcAdvance,
    output logic             FetchErr
);
    localparam int CntW = $clog2(BufDepth) + 1;

    fetch_state_t             state_q, state_d;
    logic [addrW-1:0]         addr_q, addr_d, aligned_addr;
    logic                     drop_q, drop_d;
    logic                     err_q, err_d;
    logic                     misaligned, space, space_after, push, pop, empty;
    logic [CntW-1:0]          count;
    logic [dataW+addrW-1:0]   head;

    assign aligned_addr = ProgAddr & ~addrW'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = |ProgAddr[1:0];
    assign FetchErr   = err_q;
`else
    assign misaligned = 1'b0;
    assign FetchErr   = 1'b0;
`endif

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = addr_q;
    assign PcAdvance      = imem.imem_req && imem.imem_gnt;

    assign InstrValid = !empty;
    assign Instr      = empty ? dataW'(NOP_INSTR) : head[dataW+addrW-1 -: dataW];
    assign InstrAddr  = empty ? '0 : head[addrW-1:0];

    assign pop  = InstrValid && InstrReady && !Flush;
    assign push = (state_q == WAIT) && imem.imem_rvalid && !Flush;

    // An in-flight WAIT reserves a slot so its response always has room.
    assign space       = (int'(count) + int'(state_q == WAIT)) < BufDepth;
    assign space_after = (int'(count) + int'(push) - int'(pop)) < BufDepth;

    fetch_fifo_r32i #(.Width(dataW + addrW), .Depth(BufDepth)) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (Flush),
        .wdata ({imem.imem_rdata, imem.imem_addr}),
        .head  (head),
        .count (count),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        err_d   = Flush ? 1'b0 : err_q;
        unique case (state_q)
            IDLE: begin
                if (!Flush && FetchEn && !err_q && space) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        addr_d  = aligned_addr;
                    end
                end
            end
            REQ: begin
                // The bus forbids withdrawing a request, so a flush is remembered until gnt.
                if (imem.imem_gnt) begin
                    state_d = (Flush || drop_q) ? DROP : WAIT;
                    drop_d  = 1'b0;
                end else if (Flush) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = IDLE;
                    if (!Flush && FetchEn && !err_q && space_after) begin
                        if (misaligned) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = REQ;
                            addr_d  = aligned_addr;
                        end
                    end
                end else if (Flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_r32i.sv
// Directed self-checking bench for fetch_r32i.
module tb_fetch_r32i;
    import fetch_pkg_r32i::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ProgAddr = '0;
    logic        FetchEn = 1'b0;
    logic        Flush = 1'b0;
    logic        InstrReady = 1'b0;
    logic [31:0] Instr, InstrAddr;
    logic        InstrValid, PcAdvance, FetchErr;

    int          checks = 0;
    int          failures = 0;
    int          n_adv = 0;
    logic        resp_pend = 1'b0;
    logic [31:0] resp_data = '0;
    logic [31:0] last_gnt_addr = '0;

    fetch_r32i_if #(.dataW(32), .addrW(32)) imem ();

    fetch_r32i #(.dataW(32), .addrW(32), .BufDepth(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .ProgAddr   (ProgAddr),
        .FetchEn    (FetchEn),
        .Flush      (Flush),
        .imem       (imem),
        .Instr      (Instr),
        .InstrAddr  (InstrAddr),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .PcAdvance  (PcAdvance),
        .FetchErr   (FetchErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        FetchEn = 1'b0; Flush = 1'b0; InstrReady = 1'b0; ProgAddr = '0;
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        resp_pend = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    // Memory that grants at once and answers the next cycle; the PC steps on each grant.
    task automatic bus_cycle();
        logic        nxt_pend;
        logic [31:0] nxt_data;
        imem.imem_gnt    = imem.imem_req;
        imem.imem_rvalid = resp_pend;
        imem.imem_rdata  = resp_data;
        #1;
        nxt_pend = imem.imem_req && imem.imem_gnt;
        nxt_data = word_of(imem.imem_addr);
        if (PcAdvance) n_adv++;
        if (nxt_pend) last_gnt_addr = imem.imem_addr;
        tick();
        resp_pend = nxt_pend;
        resp_data = nxt_data;
        if (nxt_pend) ProgAddr = ProgAddr + 32'd4;
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b0;
    endtask

    initial begin
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        do_reset();

        // reset values, then reset asserted while WAIT
        chk("rst_req", 32'(imem.imem_req), 32'd0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_iaddr", InstrAddr, 32'h0);
        chk("rst_adv", 32'(PcAdvance), 32'd0);
        chk("rst_err", 32'(FetchErr), 32'd0);
        ProgAddr = 32'h40; FetchEn = 1'b1;
        tick();
        chk("t1_req", 32'(imem.imem_req), 32'd1);
        chk("t1_addr", imem.imem_addr, 32'h40);
        imem.imem_gnt = 1'b1;
        #1 chk("t1_adv", 32'(PcAdvance), 32'd1);
        tick();
        imem.imem_gnt = 1'b0; ProgAddr = 32'h80;
        #1 reset = 1'b1;
        #1;
        chk("t1_rst_req", 32'(imem.imem_req), 32'd0);
        chk("t1_rst_valid", 32'(InstrValid), 32'd0);
        chk("t1_rst_instr", Instr, 32'h0000_0013);
        reset = 1'b0;
        tick();
        chk("t1_rel_req", 32'(imem.imem_req), 32'd1);
        chk("t1_rel_addr", imem.imem_addr, 32'h80);

        // minimum latency single fetch
        do_reset();
        ProgAddr = 32'h100; FetchEn = 1'b1; InstrReady = 1'b1;
        tick();
        chk("t2_addr", imem.imem_addr, 32'h100);
        imem.imem_gnt = 1'b1; FetchEn = 1'b0;
        #1 chk("t2_adv", 32'(PcAdvance), 32'd1);
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0050_0093;
        #1;
        chk("t2_adv_pulse", 32'(PcAdvance), 32'd0);
        chk("t2_valid_early", 32'(InstrValid), 32'd0);
        tick();
        imem.imem_rvalid = 1'b0;
        chk("t2_valid", 32'(InstrValid), 32'd1);
        chk("t2_instr", Instr, 32'h0050_0093);
        chk("t2_iaddr", InstrAddr, 32'h100);
        tick();
        chk("t2_popped", 32'(InstrValid), 32'd0);

        // buffer saturates at two entries
        do_reset();
        ProgAddr = 32'h0; FetchEn = 1'b1; n_adv = 0;
        repeat (10) bus_cycle();
        chk("t3_nadv", 32'(n_adv), 32'd2);
        chk("t3_req_idle", 32'(imem.imem_req), 32'd0);
        chk("t3_valid", 32'(InstrValid), 32'd1);
        chk("t3_head_instr", Instr, word_of(32'h0));
        chk("t3_head_addr", InstrAddr, 32'h0);
        InstrReady = 1'b1;
        bus_cycle();
        InstrReady = 1'b0;
        chk("t3_pop_addr", InstrAddr, 32'h4);
        chk("t3_pop_instr", Instr, word_of(32'h4));
        n_adv = 0;
        for (int i = 0; i < 6 && n_adv == 0; i++) bus_cycle();
        chk("t3_refill_timeout", 32'(n_adv), 32'd1);
        chk("t3_refill_addr", last_gnt_addr, 32'h8);
        repeat (2) bus_cycle();
        chk("t5_full_valid", 32'(InstrValid), 32'd1);

        // flush with same-cycle pop on a full buffer
        Flush = 1'b1; InstrReady = 1'b1;
        tick();
        Flush = 1'b0; InstrReady = 1'b0;
        chk("t5_flush_valid", 32'(InstrValid), 32'd0);
        chk("t5_flush_instr", Instr, 32'h0000_0013);
        chk("t5_flush_iaddr", InstrAddr, 32'h0);
        ProgAddr = 32'h200;
        repeat (3) bus_cycle();
        chk("t5_after_addr", InstrAddr, 32'h200);
        chk("t5_after_instr", Instr, word_of(32'h200));

        // flush during WAIT for 0x8 drops the response
        do_reset();
        ProgAddr = 32'h4; FetchEn = 1'b1;
        repeat (4) bus_cycle();
        chk("t4_last_gnt", last_gnt_addr, 32'h8);
        Flush = 1'b1;
        #1 chk("t4_pre_valid", 32'(InstrValid), 32'd1);
        tick();
        Flush = 1'b0; ProgAddr = 32'h40;
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t4_drop_valid", 32'(InstrValid), 32'd0);
        chk("t4_drop_req", 32'(imem.imem_req), 32'd0);
        tick();
        imem.imem_rvalid = 1'b0;
        chk("t4_dropped_valid", 32'(InstrValid), 32'd0);
        tick();
        chk("t4_next_req", 32'(imem.imem_req), 32'd1);
        chk("t4_next_addr", imem.imem_addr, 32'h40);

        // flush while REQ with gnt held off
        do_reset();
        ProgAddr = 32'h300; FetchEn = 1'b1;
        tick();
        Flush = 1'b1;
        #1 chk("t6_req0", imem.imem_addr, 32'h300);
        tick();
        Flush = 1'b0; ProgAddr = 32'h400;
        chk("t6_req_held", 32'(imem.imem_req), 32'd1);
        chk("t6_addr1", imem.imem_addr, 32'h300);
        tick();
        chk("t6_addr2", imem.imem_addr, 32'h300);
        imem.imem_gnt = 1'b1;
        #1 chk("t6_adv", 32'(PcAdvance), 32'd1);
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hCAFE_F00D;
        #1 chk("t6_drop_req", 32'(imem.imem_req), 32'd0);
        tick();
        imem.imem_rvalid = 1'b0;
        chk("t6_dropped_valid", 32'(InstrValid), 32'd0);
        tick();
        chk("t6_next_addr", imem.imem_addr, 32'h400);

        // misaligned program address
        do_reset();
        ProgAddr = 32'h102; FetchEn = 1'b1;
        tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        tick();
        chk("t7_mis_req", 32'(imem.imem_req), 32'd0);
        chk("t7_mis_err", 32'(FetchErr), 32'd1);
        repeat (2) tick();
        chk("t7_err_held", 32'(FetchErr), 32'd1);
        Flush = 1'b1; FetchEn = 1'b0;
        tick();
        Flush = 1'b0;
        chk("t7_err_clr", 32'(FetchErr), 32'd0);
        chk("t7_clr_req", 32'(imem.imem_req), 32'd0);
`else
        chk("t7_mis_req", 32'(imem.imem_req), 32'd1);
        chk("t7_mis_addr", imem.imem_addr, 32'h100);
        chk("t7_mis_err", 32'(FetchErr), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
